// File: rtl/fifo_host_pkg.sv
// fifo_host_pkg: state encoding and queue command codes shared by fifo_host_ctrl.
package fifo_host_pkg;

  // Five-state command sequencer: one issue cycle and one check cycle per queue command.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_INS = 3'd1,
    CHECK_INS = 3'd2,
    ISSUE_DEL = 3'd3,
    CHECK_DEL = 3'd4
  } hostState_t;

  // Polarity of fifo_insert_delete.
  localparam logic CMD_INSERT = 1'b1;
  localparam logic CMD_DELETE = 1'b0;

  // True for the two states that present a command to the queue.
  function automatic logic isIssueState(input hostState_t s);
    return (s == ISSUE_INS) || (s == ISSUE_DEL);
  endfunction

endpackage

// File: rtl/fifo_host_ctrl.sv
// fifo_host_ctrl: turns single-cycle push/pop requests into insert/delete command
// cycles on an external queue, checks the queue's full/empty reply and reports the
// result as one-cycle pulses. A push and pop requested together are run back to back.
// Optional occupancy counter output 'level' is built when FIFO_HOST_LEVEL_EN is defined.
module fifo_host_ctrl
  import fifo_host_pkg::*;
#(
  parameter int DataWide     = 8,
  parameter int AddressDepth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_req,
  input  logic [DataWide-1:0] push_data,
  input  logic                pop_req,
  output logic [DataWide-1:0] pop_data,
  output logic                pop_valid,
  output logic                busy,
  output logic                overflow_err,
  output logic                underflow_err,
  output logic                fifo_cs,
  output logic                fifo_insert_delete,
  output logic [DataWide-1:0] fifo_data_in,
  input  logic [DataWide-1:0] fifo_data_out,
  input  logic                fifo_full,
  input  logic                fifo_empty
`ifdef FIFO_HOST_LEVEL_EN
  ,
  output logic [AddressDepth:0] level
`endif
);

  hostState_t          r_state;
  hostState_t          w_nextState;
  logic                r_pendPop;
  logic [DataWide-1:0] r_pushData;
  logic [DataWide-1:0] r_popData;
  logic                r_popValid;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_fifoCs;
  logic                w_insertDelete;
  logic [DataWide-1:0] w_dataIn;
  logic                w_busy;

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: requests are only looked at in IDLE, and push wins over pop.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (push_req) begin
          w_nextState = ISSUE_INS;
        end else if (pop_req) begin
          w_nextState = ISSUE_DEL;
        end
      end
      ISSUE_INS: w_nextState = CHECK_INS;
      CHECK_INS: w_nextState = r_pendPop ? ISSUE_DEL : IDLE;
      ISSUE_DEL: w_nextState = CHECK_DEL;
      CHECK_DEL: w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Queue-facing outputs are pure functions of the state, so reset clears them at once.
  always_comb begin
    w_fifoCs       = isIssueState(r_state);
    w_insertDelete = (r_state == ISSUE_INS) ? CMD_INSERT : CMD_DELETE;
    w_dataIn       = (r_state == ISSUE_INS) ? r_pushData : '0;
    w_busy         = (r_state != IDLE);
  end

  // Request capture and result registers; pulses default low and fire from the check states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pushData  <= '0;
      r_pendPop   <= 1'b0;
      r_popData   <= '0;
      r_popValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_popValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (push_req) begin
            r_pushData <= push_data;
            r_pendPop  <= pop_req;
          end
        end
        CHECK_INS: begin
          r_overflow <= fifo_full;
          r_pendPop  <= 1'b0;
        end
        CHECK_DEL: begin
          if (fifo_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_popData  <= fifo_data_out;
            r_popValid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FIFO_HOST_LEVEL_EN
  localparam logic [AddressDepth:0] LevelStep = (AddressDepth + 1)'(1);

  logic [AddressDepth:0] r_level;

  // Occupancy tracks only commands the queue accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if ((r_state == CHECK_INS) && !fifo_full) begin
      r_level <= r_level + LevelStep;
    end else if ((r_state == CHECK_DEL) && !fifo_empty) begin
      r_level <= r_level - LevelStep;
    end
  end

  assign level = r_level;
`endif

  assign pop_data           = r_popData;
  assign pop_valid          = r_popValid;
  assign busy               = w_busy;
  assign overflow_err       = r_overflow;
  assign underflow_err      = r_underflow;
  assign fifo_cs            = w_fifoCs;
  assign fifo_insert_delete = w_insertDelete;
  assign fifo_data_in       = w_dataIn;

endmodule

// File: tb/tb_fifo_host_ctrl.sv
// tb_fifo_host_ctrl: drives fifo_host_ctrl against a behavioural queue, predicts every
// output per cycle from a transaction-level model, and pins the model with literal checks.
// Build with FIFO_HOST_LEVEL_EN defined to also check the level output.
module tb_fifo_host_ctrl;

  localparam int DW       = 8;
  localparam int AD       = 4;
  localparam int Capacity = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_req = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          busy;
  logic          overflow_err;
  logic          underflow_err;
  logic          fifo_cs;
  logic          fifo_insert_delete;
  logic [DW-1:0] fifo_data_in;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_full;
  logic          fifo_empty;
`ifdef FIFO_HOST_LEVEL_EN
  logic [AD:0]   level;
`endif

  fifo_host_ctrl #(.DataWide(DW), .AddressDepth(AD)) dut (
    .clk(clk),
    .rst(rst),
    .push_req(push_req),
    .push_data(push_data),
    .pop_req(pop_req),
    .pop_data(pop_data),
    .pop_valid(pop_valid),
    .busy(busy),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err),
    .fifo_cs(fifo_cs),
    .fifo_insert_delete(fifo_insert_delete),
    .fifo_data_in(fifo_data_in),
    .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
`ifdef FIFO_HOST_LEVEL_EN
    ,
    .level(level)
`endif
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural queue: 15 usable entries, flags and read data registered on the command edge.
  logic [DW-1:0] qMem [16];
  int qHead = 0;
  int qCount = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qHead = 0;
      qCount = 0;
      fifo_full <= 1'b0;
      fifo_empty <= 1'b0;
      fifo_data_out <= '0;
    end else if (fifo_cs) begin
      if (fifo_insert_delete) begin
        fifo_full <= (qCount == Capacity);
        if (qCount < Capacity) begin
          qMem[(qHead + qCount) & 15] = fifo_data_in;
          qCount = qCount + 1;
        end
      end else begin
        fifo_empty <= (qCount == 0);
        if (qCount > 0) begin
          fifo_data_out <= qMem[qHead];
          qHead = (qHead + 1) & 15;
          qCount = qCount - 1;
        end
      end
    end
  end

  // Reference model: per-cycle expectation slots, filled when a request is accepted.
  typedef struct packed {
    logic          cs;
    logic          ins;
    logic [DW-1:0] din;
    logic          busy;
    logic          popValid;
    logic          ovf;
    logic          unf;
    logic          setPop;
    logic [DW-1:0] popVal;
    logic          setLvl;
    logic [AD:0]   lvl;
  } slot_t;

  slot_t         sched [64];
  logic [DW-1:0] modelQ [$];
  int            cyc = 0;
  int            busyLast = -100;
  int            popBase;
  bit            doPop;
  logic [DW-1:0] popWord;
  logic [DW-1:0] expPopData = '0;
  logic [AD:0]   expLevel = '0;
  bit            checkEn = 1'b0;

  function automatic int idx(input int c);
    return c & 63;
  endfunction

  // Model: a request is taken only if the block was idle in the previous cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sched[i] = '0;
      modelQ.delete();
      busyLast = -100;
      expPopData = '0;
      expLevel = '0;
    end else begin
      cyc = cyc + 1;
      sched[idx(cyc - 1)] = '0;
      if (sched[idx(cyc)].setPop) expPopData = sched[idx(cyc)].popVal;
      if (sched[idx(cyc)].setLvl) expLevel = sched[idx(cyc)].lvl;
      if (cyc >= busyLast + 2) begin
        doPop = 1'b0;
        popBase = cyc;
        if (push_req) begin
          sched[idx(cyc)].cs = 1'b1;
          sched[idx(cyc)].ins = 1'b1;
          sched[idx(cyc)].din = push_data;
          sched[idx(cyc)].busy = 1'b1;
          sched[idx(cyc + 1)].busy = 1'b1;
          if (modelQ.size() >= Capacity) begin
            sched[idx(cyc + 2)].ovf = 1'b1;
          end else begin
            modelQ.push_back(push_data);
            sched[idx(cyc + 2)].setLvl = 1'b1;
            sched[idx(cyc + 2)].lvl = (AD + 1)'(modelQ.size());
          end
          busyLast = cyc + 1;
          if (pop_req) begin
            doPop = 1'b1;
            popBase = cyc + 2;
          end
        end else if (pop_req) begin
          doPop = 1'b1;
        end
        if (doPop) begin
          sched[idx(popBase)].cs = 1'b1;
          sched[idx(popBase)].busy = 1'b1;
          sched[idx(popBase + 1)].busy = 1'b1;
          if (modelQ.size() == 0) begin
            sched[idx(popBase + 2)].unf = 1'b1;
          end else begin
            popWord = modelQ.pop_front();
            sched[idx(popBase + 2)].popValid = 1'b1;
            sched[idx(popBase + 2)].setPop = 1'b1;
            sched[idx(popBase + 2)].popVal = popWord;
            sched[idx(popBase + 2)].setLvl = 1'b1;
            sched[idx(popBase + 2)].lvl = (AD + 1)'(modelQ.size());
          end
          busyLast = popBase + 1;
        end
      end
    end
  end

  // Compare every output against the model on the falling edge.
  slot_t cmpSlot;
  always @(negedge clk) begin
    if (checkEn) begin
      cmpSlot = sched[idx(cyc)];
      checkOutput("fifo_cs", 32'(fifo_cs), 32'(cmpSlot.cs));
      checkOutput("fifo_insert_delete", 32'(fifo_insert_delete), 32'(cmpSlot.ins));
      checkOutput("fifo_data_in", 32'(fifo_data_in), 32'(cmpSlot.din));
      checkOutput("busy", 32'(busy), 32'(cmpSlot.busy));
      checkOutput("pop_valid", 32'(pop_valid), 32'(cmpSlot.popValid));
      checkOutput("pop_data", 32'(pop_data), 32'(expPopData));
      checkOutput("overflow_err", 32'(overflow_err), 32'(cmpSlot.ovf));
      checkOutput("underflow_err", 32'(underflow_err), 32'(cmpSlot.unf));
`ifdef FIFO_HOST_LEVEL_EN
      checkOutput("level", 32'(level), 32'(expLevel));
`endif
    end
  end

  // Drive one request for exactly one rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic p, input logic q, input logic [DW-1:0] d);
    push_req = p;
    pop_req = q;
    push_data = d;
    @(negedge clk);
    push_req = 1'b0;
    pop_req = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  int busyCnt;
  int csCnt;
  int pvCnt;
  int errCnt;
  int pPush;
  int pPop;

  initial begin
    resetDut();
    checkEn = 1'b1;
    checkOutput("reset_pop_data", 32'(pop_data), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_fifo_cs", 32'(fifo_cs), 32'h0);

    // Push 0xA5 then pop it back.
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkOutput("push_cs", 32'(fifo_cs), 32'h1);
    checkOutput("push_cmd", 32'(fifo_insert_delete), 32'h1);
    checkOutput("push_data_in", 32'(fifo_data_in), 32'hA5);
    waitCycles(1);
    checkOutput("push_check_cs", 32'(fifo_cs), 32'h0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop_cmd", 32'(fifo_insert_delete), 32'h0);
    waitCycles(2);
    checkOutput("pop_valid_a5", 32'(pop_valid), 32'h1);
    checkOutput("pop_data_a5", 32'(pop_data), 32'hA5);

    // Pop on an empty queue.
    resetDut();
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitCycles(2);
    checkOutput("underflow_pulse", 32'(underflow_err), 32'h1);
    checkOutput("underflow_no_valid", 32'(pop_valid), 32'h0);
    checkOutput("underflow_pop_data", 32'(pop_data), 32'h0);
    waitCycles(1);
    checkOutput("underflow_one_cycle", 32'(underflow_err), 32'h0);

    // Fill past capacity.
    resetDut();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      waitCycles(2);
      checkOutput("fill_overflow", 32'(overflow_err), (i == 15) ? 32'h1 : 32'h0);
    end
`ifdef FIFO_HOST_LEVEL_EN
    checkOutput("fill_level", 32'(level), 32'd15);
`endif

    // Simultaneous push and pop on an empty queue.
    resetDut();
    applyStimulus(1'b1, 1'b1, 8'h3C);
    checkOutput("both_ins_cmd", 32'(fifo_insert_delete), 32'h1);
    busyCnt = int'(busy);
    for (int k = 1; k <= 4; k++) begin
      waitCycles(1);
      busyCnt += int'(busy);
      if (k == 2) begin
        checkOutput("both_del_cs", 32'(fifo_cs), 32'h1);
        checkOutput("both_del_cmd", 32'(fifo_insert_delete), 32'h0);
      end
      if (k == 4) begin
        checkOutput("both_pop_valid", 32'(pop_valid), 32'h1);
        checkOutput("both_pop_data", 32'(pop_data), 32'h3C);
      end
    end
    checkOutput("both_busy_cycles", 32'(busyCnt), 32'd4);

    // Pop request while busy is ignored.
    resetDut();
    applyStimulus(1'b1, 1'b0, 8'h77);
    waitCycles(2);
    applyStimulus(1'b0, 1'b1, 8'h00);
    csCnt = int'(fifo_cs);
    pvCnt = 0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    csCnt += int'(fifo_cs);
    for (int k = 0; k < 6; k++) begin
      waitCycles(1);
      csCnt += int'(fifo_cs);
      pvCnt += int'(pop_valid);
    end
    checkOutput("busy_pop_cs_count", 32'(csCnt), 32'd1);
    checkOutput("busy_pop_valid_count", 32'(pvCnt), 32'd1);

    // Reset during the delete issue cycle.
    resetDut();
    applyStimulus(1'b1, 1'b0, 8'h55);
    waitCycles(2);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("rst_mid_cs_before", 32'(fifo_cs), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_cs_drop", 32'(fifo_cs), 32'h0);
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    errCnt = 0;
    for (int k = 0; k < 5; k++) begin
      waitCycles(1);
      errCnt += int'(pop_valid) + int'(underflow_err);
    end
    checkOutput("rst_mid_no_pulse", 32'(errCnt), 32'd0);

    // Randomized traffic: fill-biased then drain-biased, with occasional resets.
    resetDut();
    for (int i = 0; i < 800; i++) begin
      pPush = (i < 400) ? 55 : 20;
      pPop  = (i < 400) ? 20 : 55;
      if ($urandom_range(0, 249) == 0) begin
        push_req = 1'b0;
        pop_req = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        push_req = ($urandom_range(0, 99) < pPush);
        pop_req = ($urandom_range(0, 99) < pPop);
        push_data = 8'($urandom);
        @(negedge clk);
      end
    end
    push_req = 1'b0;
    pop_req = 1'b0;
    waitCycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fifo_host_ctrl.md
FIFO_HOST_CTRL -- requirements
Module: fifo_host_ctrl

Interface
REQ-001 The block SHALL have parameter DataWide, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter AddressDepth, default 4, giving queue storage of 2^AddressDepth entries and usable capacity 2^AddressDepth-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 push_req  input  1  single-cycle request to enqueue push_data.
REQ-006 push_data  input  DataWide  word to enqueue, sampled with push_req.
REQ-007 pop_req  input  1  single-cycle request to dequeue one word.
REQ-008 pop_data  output  DataWide  last dequeued word, registered.
REQ-009 pop_valid  output  1  one-cycle pulse when pop_data is updated.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 overflow_err  output  1  one-cycle pulse when the queue rejects an insert.
REQ-012 underflow_err  output  1  one-cycle pulse when the queue reports empty on a delete.
REQ-013 fifo_cs  output  1  chip select to the queue.
REQ-014 fifo_insert_delete  output  1  queue command: 1 = insert, 0 = delete.
REQ-015 fifo_data_in  output  DataWide  write data to the queue.
REQ-016 fifo_data_out  input  DataWide  queue read data, valid one edge after a delete command.
REQ-017 fifo_full / fifo_empty  input  1 each  queue status flags, registered by the queue on the command edge.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE_INS, CHECK_INS, ISSUE_DEL and CHECK_DEL.
REQ-019 Requests SHALL be accepted only in IDLE; push_req or pop_req arriving while busy=1 SHALL be ignored.
REQ-020 When push_req=1 in IDLE, the block SHALL capture push_data and enter ISSUE_INS.
REQ-021 In ISSUE_INS, the block SHALL drive fifo_cs=1, fifo_insert_delete=1 and fifo_data_in=captured word for exactly one cycle, then enter CHECK_INS.
REQ-022 In CHECK_INS, the block SHALL drive fifo_cs=0 and sample fifo_full; if fifo_full=1 it SHALL pulse overflow_err, then return to IDLE.
REQ-023 When pop_req=1 in IDLE without push_req, the block SHALL enter ISSUE_DEL.
REQ-024 In ISSUE_DEL, the block SHALL drive fifo_cs=1 and fifo_insert_delete=0 for one cycle, then enter CHECK_DEL.
REQ-025 In CHECK_DEL, if fifo_empty=1 the block SHALL pulse underflow_err and leave pop_data unchanged; otherwise it SHALL load pop_data from fifo_data_out and pulse pop_valid.
REQ-026 When push_req and pop_req are both 1 in IDLE, the block SHALL service the push first, latch a pending pop, and enter ISSUE_DEL directly from CHECK_INS without visiting IDLE.
REQ-027 Latency SHALL be three cycles from request to the result pulse: request edge, ISSUE edge, CHECK edge.
REQ-028 fifo_cs SHALL be 0 in every state except ISSUE_INS and ISSUE_DEL.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE and clear the pending pop.
REQ-030 rst=1 SHALL immediately clear all outputs to 0: pop_data, pop_valid, busy, both error flags, fifo_cs, fifo_insert_delete and fifo_data_in.
REQ-031 A reset asserted mid-command SHALL abandon that command with no error or valid pulse.

Configuration
REQ-032 With macro FIFO_HOST_LEVEL_EN defined, the block SHALL provide output level[AddressDepth:0].
REQ-033 With FIFO_HOST_LEVEL_EN defined, level SHALL increment on a successful CHECK_INS, decrement on a successful CHECK_DEL, and reset to 0.
REQ-034 Without FIFO_HOST_LEVEL_EN, the level port and its counter SHALL be absent.

Structure
REQ-035 Package fifo_host_pkg SHALL hold the FSM state enum and the constants CMD_INSERT=1 and CMD_DELETE=0.
REQ-036 No sub-module SHALL be used; the FSM and datapath SHALL be a single module.

Verification
REQ-037 Reset, then push 0xA5, then pop: the queue SHALL see one insert cycle; pop_valid SHALL pulse with pop_data=0xA5 three cycles after pop_req.
REQ-038 Pop after reset: underflow_err SHALL pulse once, pop_data SHALL remain 0x00, and pop_valid SHALL stay 0.
REQ-039 16 pushes of 0x00..0x0F: pushes 1-15 SHALL succeed; push 16 SHALL pulse overflow_err; level SHALL read 15 (with FIFO_HOST_LEVEL_EN).
REQ-040 push_req and pop_req together with push_data=0x3C on an empty queue: the sequence SHALL be insert, then delete back-to-back, then pop_valid with 0x3C; busy SHALL stay high for 4 cycles.
REQ-041 pop_req while busy=1: the request SHALL be ignored and no second delete cycle SHALL appear on fifo_cs.
REQ-042 rst asserted during ISSUE_DEL: fifo_cs SHALL drop immediately, with no pop_valid and no underflow_err.
